// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned HW_W  = 16;
  localparam int unsigned ROW_W = PC_W - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_REDIR = 2'd2
  } fetch_state_e;

  // IR_0 mux: even halfword lives in bank 0, odd halfword in bank 1
  localparam logic [1:0] SEL0_BANK0 = 2'd0;
  localparam logic [1:0] SEL0_BANK1 = 2'd2;
  // IR_1 mux: bank 1 same row, or bank 0 at row + pc_1
  localparam logic       SEL1_BANK0 = 1'b0;
  localparam logic       SEL1_BANK1 = 1'b1;

  typedef struct packed {
    logic [HW_W-1:0] hi;
    logic [HW_W-1:0] lo;
  } hw_pair_t;

endpackage

// File: rtl/fetch_hq.sv
// Halfword circular queue: push two, pop up to two, registered head/head+1 view.
module fetch_hq
  import fetch_pkg::*;
#(
  parameter int unsigned Q_DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(Q_DEPTH),
  localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  hw_pair_t         push_data,
  input  logic [1:0]       pop_n,
  output logic [HW_W-1:0]  head0,
  output logic [HW_W-1:0]  head1,
  output logic [1:0]       valid,
  output logic [CNT_W-1:0] count
);

  logic [HW_W-1:0]  mem     [Q_DEPTH];
  logic [HW_W-1:0]  nxt_mem [Q_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, nxt_rd, nxt_wr, wr_ptr1, nxt_rd1;
  logic [CNT_W-1:0] nxt_cnt;
  logic [1:0]       nxt_valid;

  assign wr_ptr1 = wr_ptr + PTR_W'(1);
  assign nxt_rd1 = nxt_rd + PTR_W'(1);

  // Pop frees slots before the push writes, so a full queue can pop 2 and refill 2.
  always_comb begin
    nxt_rd  = rd_ptr;
    nxt_wr  = wr_ptr;
    nxt_cnt = count;
    for (int i = 0; i < Q_DEPTH; i++) nxt_mem[i] = mem[i];
    if (flush) begin
      nxt_rd  = '0;
      nxt_wr  = '0;
      nxt_cnt = '0;
    end else begin
      if (push) begin
        nxt_mem[wr_ptr]  = push_data.lo;
        nxt_mem[wr_ptr1] = push_data.hi;
        nxt_wr           = wr_ptr + PTR_W'(2);
      end
      nxt_rd  = rd_ptr + PTR_W'(pop_n);
      nxt_cnt = count + CNT_W'({push, 1'b0}) - CNT_W'(pop_n);
    end
    nxt_valid = (nxt_cnt >= CNT_W'(2)) ? 2'b11 :
                (nxt_cnt == CNT_W'(1)) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Q_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head0  <= '0;
      head1  <= '0;
      valid  <= 2'b00;
    end else begin
      for (int i = 0; i < Q_DEPTH; i++) mem[i] <= nxt_mem[i];
      rd_ptr <= nxt_rd;
      wr_ptr <= nxt_wr;
      count  <= nxt_cnt;
      head0  <= nxt_mem[nxt_rd];
      head1  <= nxt_mem[nxt_rd1];
      valid  <= nxt_valid;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Thumb fetch front end driving the dual-bank program ROM and a halfword queue to decode.
// Optional FETCH_PERF_EN adds perf_fetch/perf_stall saturating counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int unsigned     Q_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_en,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic [1:0]       dec_take,
  output logic [HW_W-1:0]  out_instr0,
  output logic [HW_W-1:0]  out_instr1,
  output logic [1:0]       out_valid,
  output logic [PC_W-1:0]  fetch_pc,
  output logic [ROW_W-1:0] Rom_addr_in,
  output logic             pc_1,
  output logic             sel_mem_1,
  output logic [1:0]       sel_mem_0,
  input  logic [HW_W-1:0]  IR_0,
  input  logic [HW_W-1:0]  IR_1
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch,
  output logic [31:0]      perf_stall
`endif
);

  localparam int unsigned    CNT_W   = $clog2(Q_DEPTH + 1);
  localparam logic [PC_W-1:0] PC_INIT = RESET_PC & ~PC_W'(1);

  fetch_state_e     state, nxt_state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] count, free_after;
  logic [1:0]       take_max, pop_n;
  logic             push;

  // ROM address and bank muxes follow the PC combinationally.
  always_comb begin
    Rom_addr_in = pc[PC_W-1:2];
    pc_1        = pc[1];
    sel_mem_0   = pc[1] ? SEL0_BANK1 : SEL0_BANK0;
    sel_mem_1   = pc[1] ? SEL1_BANK0 : SEL1_BANK1;
  end

  // The IDLE->FETCH cycle already fetches so the first pair lands one cycle after enable.
  always_comb begin
    take_max   = (count >= CNT_W'(2)) ? 2'd2 : count[1:0];
    pop_n      = (redirect_valid || dec_take > take_max) ? 2'd0 : dec_take;
    free_after = CNT_W'(Q_DEPTH) - count + CNT_W'(pop_n);
    push       = !redirect_valid && fetch_en && (state != S_REDIR) &&
                 (free_after >= CNT_W'(2));
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      S_IDLE:  if (fetch_en) nxt_state = S_FETCH;
      S_FETCH: if (!fetch_en) nxt_state = S_IDLE;
      S_REDIR: nxt_state = fetch_en ? S_FETCH : S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
    if (redirect_valid) nxt_state = S_REDIR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= PC_INIT;
      fetch_pc <= PC_INIT;
    end else begin
      state <= nxt_state;
      if (redirect_valid) begin
        pc       <= redirect_pc & ~PC_W'(1);
        fetch_pc <= redirect_pc & ~PC_W'(1);
      end else begin
        if (push) pc <= pc + PC_W'(4);
        fetch_pc <= fetch_pc + PC_W'({pop_n, 1'b0});
      end
    end
  end

  fetch_hq #(.Q_DEPTH(Q_DEPTH)) u_hq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ('{hi: IR_1, lo: IR_0}),
    .pop_n     (pop_n),
    .head0     (out_instr0),
    .head1     (out_instr1),
    .valid     (out_valid),
    .count     (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (push && perf_fetch != '1) perf_fetch <= perf_fetch + 32'd1;
      if (state == S_FETCH && !push && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

  a_take_legal: assert property (@(posedge clk) disable iff (!rst_n) dec_take <= take_max);
  a_pc_even:    assert property (@(posedge clk) disable iff (!rst_n) !pc[0]);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a queue-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [1:0]  dec_take;
  logic [15:0] out_instr0, out_instr1, fetch_pc;
  logic [1:0]  out_valid;
  logic [13:0] Rom_addr_in;
  logic        pc_1, sel_mem_1;
  logic [1:0]  sel_mem_0;
  logic [15:0] IR_0, IR_1;
  logic [15:0] rom_base;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of halfword byte addresses, fetch PC, head PC, redirect bubble.
  logic [15:0] q[$];
  logic [15:0] m_pc, m_fpc;
  bit          bubble;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dec_take(dec_take), .out_instr0(out_instr0),
    .out_instr1(out_instr1), .out_valid(out_valid), .fetch_pc(fetch_pc),
    .Rom_addr_in(Rom_addr_in), .pc_1(pc_1), .sel_mem_1(sel_mem_1), .sel_mem_0(sel_mem_0),
    .IR_0(IR_0), .IR_1(IR_1)
  );

  function automatic logic [15:0] hw_at(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Dual-bank ROM: bank 0 holds the halfword at row*4, bank 1 the one at row*4+2.
  always_comb begin
    rom_base = {Rom_addr_in, 2'b00};
    case (sel_mem_0)
      2'd0:    IR_0 = hw_at(rom_base);
      2'd2:    IR_0 = hw_at(rom_base + 16'd2);
      default: IR_0 = 16'hDEAD;
    endcase
    IR_1 = sel_mem_1 ? hw_at(rom_base + 16'd2) : hw_at(rom_base + {13'd0, pc_1, 2'b00});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = 16'h0000;
    m_fpc  = 16'h0000;
    bubble = 1'b0;
  endtask

  task automatic model_cycle(input bit fe, input bit rv, input logic [15:0] rpc,
                             input int take);
    if (rv) begin
      q.delete();
      m_pc   = rpc & 16'hFFFE;
      m_fpc  = m_pc;
      bubble = 1'b1;
    end else begin
      for (int i = 0; i < take; i++) void'(q.pop_front());
      m_fpc = m_fpc + 16'(2 * take);
      if (fe && !bubble && (4 - q.size()) >= 2) begin
        q.push_back(m_pc);
        q.push_back(m_pc + 16'd2);
        m_pc = m_pc + 16'd4;
      end
      bubble = 1'b0;
    end
  endtask

  task automatic compare_all(input string ph);
    int n;
    n = q.size();
    check({ph, ":row"},   32'(Rom_addr_in), 32'(m_pc[15:2]));
    check({ph, ":pc_1"},  32'(pc_1),        32'(m_pc[1]));
    check({ph, ":sel0"},  32'(sel_mem_0),   m_pc[1] ? 32'd2 : 32'd0);
    check({ph, ":sel1"},  32'(sel_mem_1),   m_pc[1] ? 32'd0 : 32'd1);
    check({ph, ":valid"}, 32'(out_valid),   (n >= 2) ? 32'd3 : 32'(n));
    check({ph, ":fpc"},   32'(fetch_pc),    32'(m_fpc));
    if (n >= 1) check({ph, ":instr0"}, 32'(out_instr0), 32'(hw_at(q[0])));
    if (n >= 2) check({ph, ":instr1"}, 32'(out_instr1), 32'(hw_at(q[1])));
  endtask

  function automatic int avail();
    return (q.size() >= 2) ? 2 : q.size();
  endfunction

  task automatic step(input bit fe, input bit rv, input logic [15:0] rpc, input int take,
                      input string ph);
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_take       = 2'(take);
    @(posedge clk);
    model_cycle(fe, rv, rpc, take);
    #1;
    compare_all(ph);
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_take = '0;
    model_reset();
    #12;
    compare_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: first pair one cycle after enable
    model_reset();
    fetch_en = 1'b1;
    #1;
    check("t1:row0", 32'(Rom_addr_in), 32'd0);
    check("t1:sel1", 32'(sel_mem_1), 32'd1);
    step(1, 0, 16'h0, 0, "t1");
    check("t1:valid", 32'(out_valid), 32'd3);
    check("t1:fpc", 32'(fetch_pc), 32'd0);

    // 2: queue fills to 4 and the PC parks at 0x0008
    step(1, 0, 16'h0, 0, "t2a");
    step(1, 0, 16'h0, 0, "t2b");
    check("t2:row_hold", 32'(Rom_addr_in), 32'd2);

    // 3: redirect to odd target, bubble, then pair visible
    step(1, 1, 16'h0007, 0, "t3a");
    check("t3:row", 32'(Rom_addr_in), 32'd1);
    check("t3:pc_1", 32'(pc_1), 32'd1);
    check("t3:sel0", 32'(sel_mem_0), 32'd2);
    check("t3:sel1", 32'(sel_mem_1), 32'd0);
    step(1, 0, 16'h0, 0, "t3b");
    check("t3:bubble", 32'(out_valid), 32'd0);
    step(1, 0, 16'h0, 0, "t3c");
    check("t3:valid", 32'(out_valid), 32'd3);
    check("t3:fpc", 32'(fetch_pc), 32'h6);

    // 4: redirect beats a same-cycle pop
    step(1, 0, 16'h0, 0, "t4a");
    step(1, 1, 16'h0020, 2, "t4b");
    check("t4:valid", 32'(out_valid), 32'd0);
    check("t4:fpc", 32'(fetch_pc), 32'h20);

    // 5: wrap at the top of the address space
    step(1, 1, 16'hFFFC, 0, "t5a");
    step(1, 0, 16'h0, avail(), "t5b");
    step(1, 0, 16'h0, avail(), "t5c");
    check("t5:fpc0", 32'(fetch_pc), 32'hFFFC);
    check("t5:wrap_pc", 32'(Rom_addr_in), 32'd0);
    step(1, 0, 16'h0, avail(), "t5d");
    check("t5:fpc1", 32'(fetch_pc), 32'h0000);

    // 6: async reset with three entries queued
    step(1, 1, 16'h0100, 0, "t6a");
    step(1, 0, 16'h0, 0, "t6b");
    step(1, 0, 16'h0, 0, "t6c");
    step(1, 0, 16'h0, 0, "t6d");
    step(0, 0, 16'h0, 1, "t6e");
    check("t6:pre_valid", 32'(out_valid), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6:valid", 32'(out_valid), 32'd0);
    check("t6:fpc", 32'(fetch_pc), 32'd0);
    check("t6:row", 32'(Rom_addr_in), 32'd0);
    fetch_en = 1'b0; dec_take = '0;
    @(posedge clk); #1;
    compare_all("t6_hold");
    rst_n = 1'b1;

    // Random traffic, occasionally aimed near the wrap point
    for (int c = 0; c < 400; c++) begin
      bit          fe, rv;
      logic [15:0] rpc;
      fe  = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
      step(fe, rv, rpc, $urandom_range(0, avail()), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
